// File: rtl/pcu_pkg.sv
// Shared defaults and types for the power-control unit blocks.
// Wrapper count, data width and buffer depth live here so sibling blocks agree.
package pcu_pkg;
  localparam int K_DEF     = 10;
  localparam int N_DEF     = 32;
  localparam int DEPTH_DEF = 16;
  localparam int LOG2_K    = $clog2(K_DEF);

  // Entry layout: data in the upper bits, wrapper address in the low clog2(k) bits.
  function automatic int entry_w(input int n, input int k);
    return n + $clog2(k);
  endfunction

  typedef enum logic [1:0] {IDLE, POP, DONE} bb_state_e;
endpackage

// File: rtl/backup_buffer_if.sv
// PCU <-> backup buffer bundle: push/restore controls in, status and restore writes out.
interface backup_buffer_if #(
  parameter int K     = pcu_pkg::K_DEF,
  parameter int N     = pcu_pkg::N_DEF,
  parameter int DEPTH = pcu_pkg::DEPTH_DEF
);
  localparam int W  = pcu_pkg::entry_w(N, K);
  localparam int CW = $clog2(DEPTH + 1);

  logic          Pwr_off;
  logic          Rst_Buffer;
  logic          PushEn_Buffer;
  logic [W-1:0]  PushVal_Buffer;
  logic          Start_Restore;
  logic          IsFull_Buffer;
  logic          IsEmpty_Buffer;
  logic [CW-1:0] Count;
  logic          Overflow;
  logic          Restore_Busy;
  logic          Restore_Done;
  logic [N-1:0]  Restore_Val;
  logic [K-1:0]  Restore_Ens;

  modport master (
    output Pwr_off, Rst_Buffer, PushEn_Buffer, PushVal_Buffer, Start_Restore,
    input  IsFull_Buffer, IsEmpty_Buffer, Count, Overflow,
           Restore_Busy, Restore_Done, Restore_Val, Restore_Ens
  );

  modport slave (
    input  Pwr_off, Rst_Buffer, PushEn_Buffer, PushVal_Buffer, Start_Restore,
    output IsFull_Buffer, IsEmpty_Buffer, Count, Overflow,
           Restore_Busy, Restore_Done, Restore_Val, Restore_Ens
  );
endinterface

// File: rtl/bb_storage.sv
// Backup buffer entry array: one write port, asynchronous read, contents never reset.
module bb_storage #(
  parameter int DEPTH = 16,
  parameter int W     = 36,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          Clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge Clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/pcu_dec.sv
// Binary to one-hot decoder; codes at or above OW decode to all zeros.
module pcu_dec #(
  parameter int IW = 4,
  parameter int OW = 10
) (
  input  logic          en,
  input  logic [IW-1:0] sel,
  output logic [OW-1:0] onehot
);
  for (genvar i = 0; i < OW; i++) begin : g_dec
    assign onehot[i] = en && (sel == IW'(i));
  end
endmodule

// File: rtl/backup_buffer.sv
// Circular backup FIFO of wrapper register values; on restore it replays entries
// oldest-first as one-hot writes so the newest value per wrapper lands last.
module backup_buffer
  import pcu_pkg::*;
#(
  parameter int K     = K_DEF,
  parameter int N     = N_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input logic            Clk,
  input logic            Rst,
  backup_buffer_if.slave bus
);
  localparam int KW = $clog2(K);
  localparam int W  = entry_w(N, K);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  bb_state_e     state, state_d;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          overflow;
  logic [W-1:0]  rd_entry;
  logic          live, full, push_try, push_ok, pop;

  // Power-off freezes everything; only the async reset still acts.
  assign live     = !bus.Pwr_off;
  assign full     = (count == CW'(DEPTH));
  assign push_try = live && !bus.Rst_Buffer && (state == IDLE) && bus.PushEn_Buffer;
  assign push_ok  = push_try && !full;
  assign pop      = live && (state == POP);

  always_comb begin
    state_d = state;
    if (live) begin
      if (bus.Rst_Buffer) state_d = IDLE;
      else begin
        case (state)
          // A push in the start cycle joins the restore, so it counts as non-empty.
          IDLE:    if (bus.Start_Restore) state_d = (count != '0 || push_ok) ? POP : DONE;
          POP:     if (count <= CW'(1)) state_d = DONE;
          DONE:    state_d = IDLE;
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (live) begin
      state <= state_d;
      if (bus.Rst_Buffer) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        overflow <= 1'b0;
      end else begin
        if (push_ok) begin
          wr_ptr <= wr_ptr + 1'b1;
          count  <= count + 1'b1;
        end
        if (push_try && full) overflow <= 1'b1;
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
          count  <= count - 1'b1;
        end
      end
    end
  end

  bb_storage #(.DEPTH(DEPTH), .W(W)) u_mem (
    .Clk   (Clk),
    .we    (push_ok),
    .waddr (wr_ptr),
    .wdata (bus.PushVal_Buffer),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );

  pcu_dec #(.IW(KW), .OW(K)) u_dec (
    .en     (pop),
    .sel    (rd_entry[KW-1:0]),
    .onehot (bus.Restore_Ens)
  );

  assign bus.Restore_Val    = pop ? rd_entry[W-1:KW] : '0;
  assign bus.Restore_Busy   = (state == POP);
  assign bus.Restore_Done   = live && (state == DONE);
  assign bus.IsFull_Buffer  = full;
  assign bus.IsEmpty_Buffer = (count == '0);
  assign bus.Count          = count;
  assign bus.Overflow       = overflow;
endmodule

// File: tb/tb_backup_buffer.sv
// Scoreboard bench for backup_buffer: restores queue expected pops, a negedge monitor checks them.
module tb_backup_buffer;
  localparam int K = 10, N = 32, DEPTH = 16;

  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  backup_buffer_if #(.K(K), .N(N), .DEPTH(DEPTH)) bus ();
  backup_buffer #(.K(K), .N(N), .DEPTH(DEPTH)) dut (.Clk(Clk), .Rst(Rst), .bus(bus));

  typedef struct { bit done; logic [K-1:0] ens; logic [N-1:0] val; } ev_t;
  typedef struct { logic [3:0] addr; logic [N-1:0] data; } ent_t;

  ev_t  exp_q[$];
  ent_t model_q[$];
  bit   model_ovf = 1'b0;
  int   n_tests = 0, n_fail = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  function automatic logic [K-1:0] ens_of(input logic [3:0] a);
    logic [K-1:0] one = 1;
    return (a < K) ? (one << a) : '0;
  endfunction

  // Monitor: every busy or done cycle consumes one expected event.
  ev_t e;
  always @(negedge Clk) begin
    if (Rst) begin
      if (bus.Pwr_off)
        chk("frozen_outs", {bus.Restore_Ens, bus.Restore_Done}, '0);
      else if (bus.Restore_Busy || bus.Restore_Done) begin
        if (exp_q.size() == 0)
          chk("unexpected_out", {bus.Restore_Busy, bus.Restore_Done}, '0);
        else begin
          e = exp_q.pop_front();
          chk("out_kind", bus.Restore_Done, e.done);
          if (!e.done) begin
            chk("restore_ens", bus.Restore_Ens, e.ens);
            chk("restore_val", bus.Restore_Val, e.val);
          end
        end
      end else
        chk("idle_outs", {bus.Restore_Ens, bus.Restore_Val}, '0);
    end
  end

  task automatic push(input logic [N-1:0] d, input logic [3:0] a);
    bus.PushEn_Buffer  = 1'b1;
    bus.PushVal_Buffer = {d, a};
    @(posedge Clk); #1;
    bus.PushEn_Buffer  = 1'b0;
    if (model_q.size() < DEPTH) model_q.push_back('{addr: a, data: d});
    else model_ovf = 1'b1;
  endtask

  task automatic chk_status(input string tag);
    @(negedge Clk);
    chk({tag, "_count"}, bus.Count, model_q.size());
    chk({tag, "_full"},  bus.IsFull_Buffer, model_q.size() == DEPTH);
    chk({tag, "_empty"}, bus.IsEmpty_Buffer, model_q.size() == 0);
    chk({tag, "_ovf"},   bus.Overflow, model_ovf);
    @(posedge Clk); #1;
  endtask

  task automatic start_restore();
    int n = model_q.size();
    foreach (model_q[i])
      exp_q.push_back('{done: 1'b0, ens: ens_of(model_q[i].addr), val: model_q[i].data});
    exp_q.push_back('{done: 1'b1, ens: '0, val: '0});
    model_q.delete();
    bus.Start_Restore = 1'b1;
    @(posedge Clk); #1;
    bus.Start_Restore = 1'b0;
    @(negedge Clk);
    chk("first_busy", bus.Restore_Busy, n != 0);
    chk("first_done", bus.Restore_Done, n == 0);
    @(posedge Clk); #1;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge Clk);
    #1;
    chk({tag, "_drained"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, want finish before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst = 1'b0;
    bus.Pwr_off = 1'b0; bus.Rst_Buffer = 1'b0; bus.PushEn_Buffer = 1'b0;
    bus.PushVal_Buffer = '0; bus.Start_Restore = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_empty", bus.IsEmpty_Buffer, 1);
    chk("rst_full",  bus.IsFull_Buffer, 0);
    chk("rst_count", bus.Count, 0);
    chk("rst_ovf",   bus.Overflow, 0);
    chk("rst_busy",  bus.Restore_Busy, 0);
    chk("rst_done",  bus.Restore_Done, 0);
    chk("rst_ens",   bus.Restore_Ens, 0);
    Rst = 1'b1;
    @(posedge Clk); #1;

    // Two pushes to wrapper 3, replayed in push order.
    push(32'hDEADBEEF, 4'd3);
    push(32'h12345678, 4'd3);
    chk_status("two");
    start_restore();
    wait_drain("two");
    chk_status("two_after");

    // Fill, then overflow; only the first 16 come back.
    for (int i = 0; i < DEPTH; i++) push(32'h1000 + i, 4'(i % K));
    chk_status("fill");
    push(32'h00000BAD, 4'd1);
    chk_status("ovf");
    start_restore();
    wait_drain("fill");

    // Restore with nothing stored.
    start_restore();
    wait_drain("empty");

    // Freeze after the second pop; Rst_Buffer and push must be ignored meanwhile.
    for (int i = 0; i < 5; i++) push(32'hA0 + i, 4'(i));
    start_restore();
    @(posedge Clk); #1;
    bus.Pwr_off = 1'b1; bus.Rst_Buffer = 1'b1;
    bus.PushEn_Buffer = 1'b1; bus.PushVal_Buffer = {32'hFFFF, 4'd2};
    @(negedge Clk);
    chk("frz_count", bus.Count, 3);
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("frz_count_end", bus.Count, 3);
    @(posedge Clk); #1;
    bus.Pwr_off = 1'b0; bus.Rst_Buffer = 1'b0; bus.PushEn_Buffer = 1'b0;
    wait_drain("frz");
    chk_status("frz_after");

    // Rst_Buffer beats a simultaneous push.
    for (int i = 0; i < 4; i++) push(32'hB0 + i, 4'(i));
    chk_status("four");
    bus.Rst_Buffer = 1'b1; bus.PushEn_Buffer = 1'b1; bus.PushVal_Buffer = {32'h77, 4'd7};
    @(posedge Clk); #1;
    bus.Rst_Buffer = 1'b0; bus.PushEn_Buffer = 1'b0;
    model_q.delete(); model_ovf = 1'b0;
    chk_status("clr");

    // Async reset mid-restore: one pop seen, then abort with no done pulse.
    push(32'hC1, 4'd1); push(32'hC2, 4'd2); push(32'hC3, 4'd3);
    exp_q.push_back('{done: 1'b0, ens: 10'h002, val: 32'hC1});
    model_q.delete();
    bus.Start_Restore = 1'b1;
    @(posedge Clk); #1;
    bus.Start_Restore = 1'b0;
    @(posedge Clk); #1;
    Rst = 1'b0;
    #1;
    chk("abort_busy",  bus.Restore_Busy, 0);
    chk("abort_ens",   bus.Restore_Ens, 0);
    chk("abort_count", bus.Count, 0);
    repeat (2) @(posedge Clk);
    #1;
    Rst = 1'b1;
    repeat (4) @(posedge Clk);
    #1;
    chk("abort_q", exp_q.size(), 0);
    chk_status("abort_after");

    // Out-of-range wrapper address pops with no enable.
    push(32'hCAFE0012, 4'd12);
    push(32'h00000055, 4'd9);
    chk_status("oor");
    start_restore();
    wait_drain("oor");
    chk_status("oor_after");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
